multi_core_hash_dispatcher: RTL
===============================

# multi_core_hash_dispatcher

Parametrised successor to the single-core hash path in the miner. It accepts one mining job (512-bit block, difficulty, nonce range) from the main controller and distributes nonces across NUM_CORES hash cores, one dispatch per cycle. It returns the first valid result as `{nonce, hash}`, aborts the remaining cores, and reports a single `hash_done`. It sits between `main_controller`/packet decoder and an array of hash-module cores, and it replaces the direct controller-to-core connection.

## Interface
Parameters:
- `NUM_CORES`, 4: number of attached hash cores (1..16).
- `NONCE_W`, 32: nonce width.
- `HASH_W`, 256: hash width; `valid_hash` is `HASH_W+NONCE_W` wide (288 at defaults).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `begin_hash`  in  1  start-job pulse; `nonce_start`/`nonce_end` are sampled in the same cycle.
- `quit_hash`  in  1  abort the current job.
- `nonce_start`  in  NONCE_W  first nonce of the range.
- `nonce_end`  in  NONCE_W  last nonce of the range, inclusive; may be below `nonce_start` (wrap).
- `core_start`  out  NUM_CORES  per-core one-cycle start pulse.
- `core_nonce`  out  NUM_CORES*NONCE_W  per-core nonce; held from start until done.
- `core_quit`  out  NUM_CORES  per-core one-cycle abort pulse.
- `core_done`  in  NUM_CORES  per-core completion pulse.
- `core_valid`  in  NUM_CORES  qualifies `core_done`: the hash met the difficulty.
- `core_hash`  in  NUM_CORES*HASH_W  per-core hash result; valid with `core_done`.
- `hash_done`  out  1  one-cycle job-complete pulse.
- `valid_hash_flag`  out  1  1 = a result was found; held until the next accepted `begin_hash`.
- `valid_hash`  out  HASH_W+NONCE_W  `{nonce, hash}` of the winning core; held.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - `begin_hash` latches `next_nonce <= nonce_start` and `remaining <= (nonce_end - nonce_start mod 2^NONCE_W) + 1` into a NONCE_W+1-bit counter.
  - Same cycle: clears `valid_hash_flag` and `valid_hash`, then moves to RUN.
- RUN, dispatch:
  - Each cycle, if `remaining != 0` and any core is idle, the lowest-index idle core gets `core_start`, `core_nonce <= next_nonce`, and its busy bit is set.
  - `next_nonce` increments modulo 2^NONCE_W; `remaining` decrements. At most one dispatch per cycle.
- RUN, completion:
  - `core_done[i]` clears busy[i]. A core freed at cycle t can be redispatched at t+1 at the earliest, never at t.
  - Any `core_done & core_valid` latches `valid_hash <= {core_nonce[i], core_hash[i]}` for the lowest such i, sets `valid_hash_flag`, suppresses that cycle's dispatch, and moves to DRAIN.
  - Done-without-valid only frees the core.
- RUN, exhaustion: `remaining == 0`, no busy cores, and no valid result -> DONE with `valid_hash_flag = 0`.
- DRAIN (1 cycle): `core_quit` pulses for every core still busy; all busy bits clear; -> DONE. Any `core_done` arriving during DRAIN is ignored.
- DONE (1 cycle): `hash_done = 1`; -> IDLE.
- `quit_hash` in RUN or DRAIN: `core_quit` pulses for all busy cores, busy bits clear, -> IDLE. No `hash_done`; `valid_hash_flag` is left unchanged. Ignored in IDLE and DONE.
- `begin_hash` outside IDLE is ignored.
- `quit_hash` and a valid `core_done` in the same cycle: quit wins; the result is discarded.
- Full range (`nonce_end == nonce_start - 1`) gives `remaining = 2^NONCE_W`. Equal start and end gives exactly 1 nonce.

## Timing
- All outputs are registered.
- Reset values: state IDLE; `core_start`, `core_quit`, `core_nonce`, `hash_done`, `valid_hash_flag`, `valid_hash` and `busy` all 0; busy bits 0; `remaining` 0.
- `rst` mid-job returns to IDLE in one cycle with no `core_quit`; cores are reset by the same `rst`.
- Latencies:
  - `begin_hash` at t -> `busy` at t+1, first `core_start` at t+1.
  - Successive dispatches to free cores occur on consecutive cycles.
  - Valid `core_done` at t -> DRAIN/`core_quit` at t+1 -> `hash_done` at t+2, with `valid_hash` stable from t+2.
  - Exhaustion: last `core_done` at t -> `hash_done` at t+1.
  - `quit_hash` at t -> `core_quit` and `busy = 0` at t+1.

## Test plan
- Range 100..103, 4 cores: start pulses on cores 0..3 with nonces 100,101,102,103 on cycles t+1..t+4. Core 2 then returns valid with hash H -> `hash_done` 2 cycles later, `valid_hash = {102, H}`, `core_quit = 4'b1011`.
- Range 0..5, 4 cores, all cores return invalid after 3 cycles: nonces 4,5 go to the first freed cores, each one cycle after their done. After the final done -> `hash_done` with `valid_hash_flag = 0`; no `core_quit`.
- Cores 1 and 3 return valid in the same cycle -> `valid_hash` carries core 1's nonce and hash.
- Range 0xFFFFFFFE..0x00000001 -> dispatch order FFFFFFFE, FFFFFFFF, 00000000, 00000001, then no further starts.
- `quit_hash` mid-run with 3 busy cores -> `core_quit` on those 3 next cycle, `busy = 0`, no `hash_done`. A `begin_hash` issued while busy is ignored.
- `rst` asserted during DRAIN -> next cycle all outputs 0, state IDLE. A new job then runs normally.

Source files
------------

// File: rtl/multi_core_hash_dispatcher.sv
// multi_core_hash_dispatcher
// Takes one mining job from the controller and hands its nonces to NUM_CORES
// hash cores, one dispatch per cycle. The first core whose hash meets the
// difficulty wins: its {nonce, hash} is latched, the other cores are told to
// quit, and a single hash_done pulse closes the job. Every output is a flop.
module multi_core_hash_dispatcher #(
  parameter int NUM_CORES = 4,
  parameter int NONCE_W   = 32,
  parameter int HASH_W    = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          begin_hash,
  input  logic                          quit_hash,
  input  logic [NONCE_W-1:0]            nonce_start,
  input  logic [NONCE_W-1:0]            nonce_end,
  output logic [NUM_CORES-1:0]          core_start,
  output logic [NUM_CORES*NONCE_W-1:0]  core_nonce,
  output logic [NUM_CORES-1:0]          core_quit,
  input  logic [NUM_CORES-1:0]          core_done,
  input  logic [NUM_CORES-1:0]          core_valid,
  input  logic [NUM_CORES*HASH_W-1:0]   core_hash,
  output logic                          hash_done,
  output logic                          valid_hash_flag,
  output logic [HASH_W+NONCE_W-1:0]     valid_hash,
  output logic                          busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                         state, state_d;
  logic [NONCE_W-1:0]             next_nonce, next_nonce_d;
  logic [NONCE_W:0]               remaining, remaining_d;
  logic [NUM_CORES-1:0]           core_busy, core_busy_d;
  logic [NUM_CORES-1:0]           still_busy;
  logic [NUM_CORES-1:0]           idle_pick;
  logic                           have_idle;
  logic                           have_win;
  logic [HASH_W+NONCE_W-1:0]      win_result;
  logic [NUM_CORES-1:0]           core_start_d;
  logic [NUM_CORES-1:0]           core_quit_d;
  logic [NUM_CORES*NONCE_W-1:0]   core_nonce_d;
  logic                           hash_done_d;
  logic                           flag_d;
  logic [HASH_W+NONCE_W-1:0]      valid_hash_d;

  // Pick the lowest core that is free after this cycle's completions, and the
  // lowest busy core reporting a valid hash; a core finishing now counts as
  // free so its next start pulse lands on the following cycle.
  always_comb begin
    still_busy = core_busy & ~core_done;
    idle_pick  = '0;
    have_idle  = 1'b0;
    have_win   = 1'b0;
    win_result = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!still_busy[i] && !have_idle) begin
        idle_pick[i] = 1'b1;
        have_idle    = 1'b1;
      end
      if (core_busy[i] && core_done[i] && core_valid[i] && !have_win) begin
        have_win   = 1'b1;
        win_result = {core_nonce[i*NONCE_W +: NONCE_W],
                      core_hash[i*HASH_W +: HASH_W]};
      end
    end
  end

  // Next-state and next-output logic. The IDLE cycle that accepts a job already
  // dispatches nonce_start to core 0, so the first start pulse appears together
  // with busy; remaining therefore loads the range size minus that one nonce.
  always_comb begin
    state_d      = state;
    next_nonce_d = next_nonce;
    remaining_d  = remaining;
    core_busy_d  = core_busy;
    core_start_d = '0;
    core_quit_d  = '0;
    core_nonce_d = core_nonce;
    hash_done_d  = 1'b0;
    flag_d       = valid_hash_flag;
    valid_hash_d = valid_hash;
    case (state)
      IDLE: begin
        if (begin_hash) begin
          state_d                     = RUN;
          flag_d                      = 1'b0;
          valid_hash_d                = '0;
          core_busy_d                 = '0;
          core_busy_d[0]              = 1'b1;
          core_start_d[0]             = 1'b1;
          core_nonce_d[NONCE_W-1:0]   = nonce_start;
          next_nonce_d                = nonce_start + NONCE_W'(1);
          remaining_d                 = {1'b0, nonce_end - nonce_start};
        end
      end
      RUN: begin
        if (quit_hash) begin
          state_d     = IDLE;
          core_quit_d = still_busy;
          core_busy_d = '0;
        end else if (have_win) begin
          state_d      = DRAIN;
          flag_d       = 1'b1;
          valid_hash_d = win_result;
          core_quit_d  = still_busy;
          core_busy_d  = '0;
        end else begin
          core_busy_d = still_busy;
          if ((remaining != '0) && have_idle) begin
            core_start_d = idle_pick;
            core_busy_d  = still_busy | idle_pick;
            for (int i = 0; i < NUM_CORES; i++) begin
              if (idle_pick[i]) begin
                core_nonce_d[i*NONCE_W +: NONCE_W] = next_nonce;
              end
            end
            next_nonce_d = next_nonce + NONCE_W'(1);
            remaining_d  = remaining - (NONCE_W+1)'(1);
          end else if ((remaining == '0) && (still_busy == '0)) begin
            state_d     = DONE;
            hash_done_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (quit_hash) begin
          state_d     = IDLE;
          core_quit_d = core_busy;
          core_busy_d = '0;
        end else begin
          state_d     = DONE;
          hash_done_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register and registered outputs; reset silences the cores without
  // a quit pulse because they share the same reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      next_nonce      <= '0;
      remaining       <= '0;
      core_busy       <= '0;
      core_start      <= '0;
      core_quit       <= '0;
      core_nonce      <= '0;
      hash_done       <= 1'b0;
      valid_hash_flag <= 1'b0;
      valid_hash      <= '0;
      busy            <= 1'b0;
    end else begin
      state           <= state_d;
      next_nonce      <= next_nonce_d;
      remaining       <= remaining_d;
      core_busy       <= core_busy_d;
      core_start      <= core_start_d;
      core_quit       <= core_quit_d;
      core_nonce      <= core_nonce_d;
      hash_done       <= hash_done_d;
      valid_hash_flag <= flag_d;
      valid_hash      <= valid_hash_d;
      busy            <= (state_d != IDLE);
    end
  end

endmodule
